// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - synchronous first-word-fall-through FIFO with count, threshold flags and sticky errors
//
// Purpose: single-clock FIFO of 2^ADDR_WIDTH words of DATA_WIDTH bits. The head
// word is always presented on o_readData (zero when empty); i_readEnable pops it.
// Occupancy is held in an ADDR_WIDTH+1 bit counter so every slot is usable.
//
// Ports:
//   i_clock        rising-edge clock
//   i_nReset       synchronous active-low reset
//   i_writeData    word to push
//   i_writeEnable  push request
//   o_fullFlag     count == DEPTH
//   o_almostFull   count >= ALMOST_FULL_LEVEL
//   i_readEnable   pop request
//   o_readData     head word, zero when empty
//   o_emptyFlag    count == 0
//   o_almostEmpty  count <= ALMOST_EMPTY_LEVEL
//   o_count        words held, 0..DEPTH
//   o_overflow     sticky: write attempted while full and not popping
//   o_underflow    sticky: read attempted while empty
//   i_clearErrors  clears both sticky error flags

module fifo_sync_param #(
   parameter int DATA_WIDTH         = 32,
   parameter int ADDR_WIDTH         = 8,
   parameter int ALMOST_FULL_LEVEL  = 240,
   parameter int ALMOST_EMPTY_LEVEL = 16
) (
   input  logic                  i_clock,
   input  logic                  i_nReset,
   input  logic [DATA_WIDTH-1:0] i_writeData,
   input  logic                  i_writeEnable,
   output logic                  o_fullFlag,
   output logic                  o_almostFull,
   input  logic                  i_readEnable,
   output logic [DATA_WIDTH-1:0] o_readData,
   output logic                  o_emptyFlag,
   output logic                  o_almostEmpty,
   output logic [ADDR_WIDTH:0]   o_count,
   output logic                  o_overflow,
   output logic                  o_underflow,
   input  logic                  i_clearErrors
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   localparam logic [ADDR_WIDTH:0]   FULL_COUNT   = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]   COUNT_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE      = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0]   ALMOST_FULL  = (ADDR_WIDTH+1)'(ALMOST_FULL_LEVEL);
   localparam logic [ADDR_WIDTH:0]   ALMOST_EMPTY = (ADDR_WIDTH+1)'(ALMOST_EMPTY_LEVEL);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] writePtr;
   logic [ADDR_WIDTH-1:0] readPtr;
   logic [ADDR_WIDTH:0]   count;
   logic                  overflowReg;
   logic                  underflowReg;

   logic readAccept;
   logic writeAccept;
   logic readReject;
   logic writeReject;

   // A pop frees the slot in the same cycle, so a push at full is still
   // accepted when paired with a pop. At empty the pop is never accepted.
   always_comb begin
      readAccept  = i_readEnable && (count != '0);
      writeAccept = i_writeEnable && ((count != FULL_COUNT) || readAccept);
      readReject  = i_readEnable && !readAccept;
      writeReject = i_writeEnable && !writeAccept;
   end

   // Storage carries no reset; stale contents are unreachable once count is 0.
   always_ff @(posedge i_clock) begin
      if (i_nReset && writeAccept) begin
         mem[writePtr] <= i_writeData;
      end
   end

   always_ff @(posedge i_clock) begin
      if (!i_nReset) begin
         writePtr <= '0;
         readPtr  <= '0;
         count    <= '0;
      end else begin
         if (writeAccept) begin
            writePtr <= writePtr + PTR_ONE;
         end
         if (readAccept) begin
            readPtr <= readPtr + PTR_ONE;
         end
         case ({writeAccept, readAccept})
            2'b10:   count <= count + COUNT_ONE;
            2'b01:   count <= count - COUNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // A new error event outranks a clear issued in the same cycle.
   always_ff @(posedge i_clock) begin
      if (!i_nReset) begin
         overflowReg  <= 1'b0;
         underflowReg <= 1'b0;
      end else begin
         if (writeReject) begin
            overflowReg <= 1'b1;
         end else if (i_clearErrors) begin
            overflowReg <= 1'b0;
         end
         if (readReject) begin
            underflowReg <= 1'b1;
         end else if (i_clearErrors) begin
            underflowReg <= 1'b0;
         end
      end
   end

   assign o_readData    = (count != '0) ? mem[readPtr] : '0;
   assign o_count       = count;
   assign o_emptyFlag   = (count == '0);
   assign o_fullFlag    = (count == FULL_COUNT);
   assign o_almostFull  = (count >= ALMOST_FULL);
   assign o_almostEmpty = (count <= ALMOST_EMPTY);
   assign o_overflow    = overflowReg;
   assign o_underflow   = underflowReg;

endmodule

// File: doc/fifo_sync_param.md
FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, so DEPTH = 2^ADDR_WIDTH words (256).
REQ-003 The block SHALL have parameter ALMOST_FULL_LEVEL, default 240, the o_almostFull threshold in words.
REQ-004 The block SHALL have parameter ALMOST_EMPTY_LEVEL, default 16, the o_almostEmpty threshold in words.
REQ-005 The block SHALL have one clock and a synchronous, active-low reset: i_clock in 1, rising-edge clock; i_nReset in 1, synchronous active-low reset.
REQ-006 The block SHALL have these write-side ports: i_writeData in DATA_WIDTH, write word; i_writeEnable in 1, write request; o_fullFlag out 1, FIFO full; o_almostFull out 1, count >= ALMOST_FULL_LEVEL.
REQ-007 The block SHALL have these read-side ports: i_readEnable in 1, pop request; o_readData out DATA_WIDTH, head word (first-word-fall-through); o_emptyFlag out 1, FIFO empty; o_almostEmpty out 1, count <= ALMOST_EMPTY_LEVEL.
REQ-008 The block SHALL have these status ports: o_count out ADDR_WIDTH+1, words held (0..DEPTH); o_overflow out 1, sticky write-while-full error; o_underflow out 1, sticky read-while-empty error; i_clearErrors in 1, clears sticky errors.

Function
REQ-009 The block SHALL be fully synchronous to i_clock, with storage of DEPTH x DATA_WIDTH and ADDR_WIDTH-bit read/write pointers wrapping modulo DEPTH.
REQ-010 The block SHALL track occupancy in an (ADDR_WIDTH+1)-bit count register, so all DEPTH words are usable (no sacrificed slot).
REQ-011 The block SHALL drive o_emptyFlag = (count == 0), o_fullFlag = (count == DEPTH), with o_almostFull and o_almostEmpty decoded from the count register, and all of these SHALL change the cycle after the causing edge.
REQ-012 The block SHALL accept a write when i_writeEnable=1 and (count < DEPTH, or a read is accepted in the same cycle); an accepted write stores at the write pointer and the write pointer increments.
REQ-013 The block SHALL accept a read when i_readEnable=1 and count > 0; an accepted read advances the read pointer.
REQ-014 The block SHALL drive o_readData with the word at the read pointer when count > 0, and with all zeros when count == 0.
REQ-015 The block SHALL make a word written into an empty FIFO visible on o_readData exactly one cycle after the write edge (write-to-read latency 1).
REQ-016 The block SHALL update count per cycle: write only +1; read only -1; both accepted, unchanged.
REQ-017 The block SHALL treat simultaneous write+read at full as both accepted: count stays DEPTH and no overflow is flagged.
REQ-018 The block SHALL treat simultaneous write+read at empty as write-only: the read is rejected, count becomes 1, and underflow is flagged.
REQ-019 The block SHALL ignore a rejected write (FIFO state unchanged) and set o_overflow the next cycle.
REQ-020 The block SHALL ignore a rejected read (pointer and count unchanged) and set o_underflow the next cycle.
REQ-021 The block SHALL clear o_overflow and o_underflow on i_clearErrors=1, except that an error event in the same cycle takes priority and the flag stays/becomes 1.
REQ-022 The block SHALL wrap pointers from DEPTH-1 to 0 with no gap or duplicate word.

Reset
REQ-023 The block SHALL, on a rising edge with i_nReset=0, set pointers and count to 0, o_overflow and o_underflow to 0, o_emptyFlag=1, o_almostEmpty=1, o_fullFlag=0, o_almostFull=0, and o_readData=0.
REQ-024 The block SHALL give reset priority over simultaneous write/read/clear; memory contents need not be cleared, and all held data is discarded by a mid-operation reset.

Verification
REQ-025 The bench SHALL cover: reset, write 0xA5A5_0001 -> next cycle o_readData=0xA5A5_0001, o_count=1, o_emptyFlag=0; read -> o_count=0, o_readData=0.
REQ-026 The bench SHALL cover: write 256 incrementing words -> o_fullFlag=1 after the 256th, o_almostFull=1 from count 240; a 257th write -> o_overflow=1 and the data is unchanged; read all -> values 0..255 in order.
REQ-027 The bench SHALL cover: at full, write+read in one cycle -> o_count stays 256, o_overflow=0, new word emerges as the 256th read.
REQ-028 The bench SHALL cover: at empty, write+read in one cycle -> o_underflow=1, o_count=1; i_clearErrors alone -> o_underflow=0; i_clearErrors with another empty read -> o_underflow stays 1.
REQ-029 The bench SHALL cover: run 1000 random push/pop cycles against a reference queue -> data order and o_count match, and pointers wrap at least 3 times.
REQ-030 The bench SHALL cover: at count 100, assert i_nReset=0 for 1 cycle with i_writeEnable=1 -> o_count=0, o_emptyFlag=1, o_readData=0, all errors 0.
